// File: rtl/pll_mon_pkg.sv
// pll_mon_pkg: shared definitions for the PLL lock monitor.
//   - pll_state_e : supervisor states (StFail is only reachable when the
//                   PLL_LOCK_MON_FAIL_EN build option is defined)
//   - default cycle constants for the monitor parameters
//   - timer_width(): width of the shared state timer
package pll_mon_pkg;

    typedef enum logic [2:0] {
        StResetPll   = 3'd0,
        StWaitLock   = 3'd1,
        StStableWait = 3'd2,
        StRun        = 3'd3,
        StFail       = 3'd4
    } pll_state_e;

    localparam int unsigned DefRstCycles    = 16;
    localparam int unsigned DefLockTimeout  = 65535;
    localparam int unsigned DefStableCycles = 1024;
    localparam int unsigned DefCntW         = 8;
    localparam int unsigned DefMaxRetry     = 4;

    // One extra bit above the largest interval so the counter never wraps
    // before a terminal-count compare can fire.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic single-bit two-flop synchroniser for asynchronous status
// inputs. Output lags the input by two clk_i edges.
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset, loads ResetVal into both flops
//   d_i    : asynchronous input
//   q_o    : synchronised output
module sync_2ff #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: pulses the PLL reset, supervises lock acquisition with
// timeout/retry, qualifies lock over a stability window before releasing the
// downstream reset, and counts lock-loss events.
//   clkin1    : PLL reference clock (sole clock)
//   rst       : synchronous active-high reset
//   pll_lock  : raw PLL LOCK, asynchronous
//   pll_rst   : reset request to the PLL
//   sys_rst   : downstream synchronous active-high reset
//   locked    : high only while running with qualified lock
//   loss_cnt  : saturating count of lock losses while running
//   retry_cnt : saturating count of consecutive lock timeouts
//   fail      : permanent failure flag
// Build option PLL_LOCK_MON_FAIL_EN: after MAX_RETRY consecutive timeouts the
// monitor parks in a failure state (PLL held in reset, fail=1) until rst.
// Without it fail is constant 0 and retries continue indefinitely.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DefRstCycles,
    parameter int unsigned LOCK_TIMEOUT  = DefLockTimeout,
    parameter int unsigned STABLE_CYCLES = DefStableCycles,
    parameter int unsigned CNT_W         = DefCntW,
    parameter int unsigned MAX_RETRY     = DefMaxRetry
) (
    input  logic             clkin1,
    input  logic             rst,
    input  logic             pll_lock,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             locked,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] retry_cnt,
    output logic             fail
);

`ifdef PLL_LOCK_MON_FAIL_EN
    localparam bit FailEn = 1'b1;
`else
    localparam bit FailEn = 1'b0;
`endif

    localparam int unsigned TimerW = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    // Terminal counts: the timer is 0 on the first cycle in a state.
    localparam logic [TimerW-1:0] RstLast     = TimerW'(RST_CYCLES - 1);
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT - 1);
    localparam logic [TimerW-1:0] StableLast  = TimerW'(STABLE_CYCLES - 1);
    localparam logic [TimerW-1:0] TimerOne    = TimerW'(1);
    localparam logic [CNT_W-1:0]  CntOne      = CNT_W'(1);
    localparam logic [CNT_W-1:0]  RetryLimit  = CNT_W'(MAX_RETRY);

    logic              lock_s;
    pll_state_e        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]  loss_q, loss_d, loss_inc;
    logic [CNT_W-1:0]  retry_q, retry_d, retry_inc;
    logic              pll_rst_q, sys_rst_q, locked_q, fail_q;

    sync_2ff #(
        .ResetVal (1'b0)
    ) u_lock_sync (
        .clk_i (clkin1),
        .rst_i (rst),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    assign loss_inc  = (loss_q == '1) ? loss_q : loss_q + CntOne;
    assign retry_inc = (retry_q == '1) ? retry_q : retry_q + CntOne;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TimerOne;
        loss_d  = loss_q;
        retry_d = retry_q;
        unique case (state_q)
            StResetPll: begin
                if (timer_q == RstLast) begin
                    state_d = StWaitLock;
                    timer_d = '0;
                end
            end
            StWaitLock: begin
                // Lock wins over a coincident timeout.
                if (lock_s) begin
                    state_d = StStableWait;
                    timer_d = '0;
                end else if (timer_q == TimeoutLast) begin
                    timer_d = '0;
                    retry_d = retry_inc;
                    if (FailEn && (retry_inc == RetryLimit)) begin
                        state_d = StFail;
                    end else begin
                        state_d = StResetPll;
                    end
                end
            end
            StStableWait: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    timer_d = '0;
                end else if (timer_q == StableLast) begin
                    state_d = StRun;
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            StRun: begin
                timer_d = '0;
                if (!lock_s) begin
                    state_d = StResetPll;
                    loss_d  = loss_inc;
                end
            end
            StFail: begin
                timer_d = '0;
            end
            default: begin
                state_d = StResetPll;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move with state_q.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            state_q   <= StResetPll;
            timer_q   <= '0;
            loss_q    <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            loss_q    <= loss_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == StResetPll) || (state_d == StFail);
            sys_rst_q <= (state_d != StRun);
            locked_q  <= (state_d == StRun);
            fail_q    <= FailEn && (state_d == StFail);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign locked    = locked_q;
    assign loss_cnt  = loss_q;
    assign retry_cnt = retry_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, MAX_RETRY=3 and CNT_W=2 (so saturation is reachable).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// Status word layout: {pll_rst, sys_rst, locked, fail, loss_cnt[1:0], retry_cnt[1:0]}.
module tb_pll_lock_monitor;

    localparam int unsigned CW = 2;

    logic          clkin1 = 1'b0;
    logic          rst = 1'b1;
    logic          pll_lock = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic          locked;
    logic [CW-1:0] loss_cnt;
    logic [CW-1:0] retry_cnt;
    logic          fail;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    pll_lock_monitor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .CNT_W         (CW),
        .MAX_RETRY     (3)
    ) dut (
        .clkin1    (clkin1),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .locked    (locked),
        .loss_cnt  (loss_cnt),
        .retry_cnt (retry_cnt),
        .fail      (fail)
    );

    always #5 clkin1 = ~clkin1;

    task automatic step();
        @(posedge clkin1);
        #1;
    endtask

    function automatic logic [7:0] status();
        return {pll_rst, sys_rst, locked, fail, loss_cnt, retry_cnt};
    endfunction

    task automatic test_reset();
        logic [7:0] obs;
        rst = 1'b1;
        pll_lock = 1'b0;
        step();
        step();
        obs = status();
        n_vec++;
        if (obs !== 8'b1100_0000) begin
            n_err++;
            $display("FAIL reset_values: got %b want %b", obs, 8'b1100_0000);
        end
        rst = 1'b0;
    endtask

    // pll_lock rises after edge 5; sync(2) + WAIT_LOCK decision(1) + 8 stable -> RUN at edge 16.
    task automatic test_bringup();
        logic [7:0] obs, exp;
        for (int c = 1; c <= 18; c++) begin
            step();
            obs = status();
            exp = {(c < 4), (c < 16), (c >= 16), 1'b0, 2'd0, 2'd0};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL bringup c=%0d: got %b want %b", c, obs, exp);
            end
            if (c == 5) pll_lock = 1'b1;
        end
    endtask

    // Loss seen at edge 3, 4-cycle PLL pulse, relock after edge 7 -> RUN at edge 18.
    task automatic test_lock_loss_run();
        logic [7:0] obs, exp;
        pll_lock = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            obs = status();
            exp = {(c >= 3 && c <= 6), (c >= 3 && c < 18), (c < 3 || c >= 18), 1'b0,
                   ((c >= 3) ? 2'd1 : 2'd0), 2'd0};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL lock_loss c=%0d: got %b want %b", c, obs, exp);
            end
            if (c == 7) pll_lock = 1'b1;
        end
    endtask

    // Lock from edge 4 reaches STABLE_WAIT at edge 7; a one-cycle drop after edge 9
    // is seen at stable count 5 (edge 12), requalification restarts -> RUN at edge 21.
    task automatic test_chatter();
        logic [7:0] obs, exp;
        pll_lock = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            step();
            obs = status();
            exp = {(c < 4), (c < 21), (c >= 21), 1'b0, 2'd0, 2'd0};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL chatter c=%0d: got %b want %b", c, obs, exp);
            end
            if (c == 4)  pll_lock = 1'b1;
            if (c == 9)  pll_lock = 1'b0;
            if (c == 10) pll_lock = 1'b1;
        end
    endtask

    // PLL pulse re-entered every 24 edges; retry_cnt saturates at 3 (or FAIL at 3).
    task automatic test_timeout();
        logic [7:0] obs, exp;
        int r;
        logic p, f;
        pll_lock = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            step();
            r = c / 24;
            if (r > 3) r = 3;
            p = ((c % 24) < 4);
            f = 1'b0;
`ifdef PLL_LOCK_MON_FAIL_EN
            if (c >= 72) begin
                p = 1'b1;
                f = 1'b1;
            end
`endif
            obs = status();
            exp = {p, 1'b1, 1'b0, f, 2'd0, 2'(r)};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL timeout c=%0d: got %b want %b", c, obs, exp);
            end
        end
    endtask

`ifdef PLL_LOCK_MON_FAIL_EN
    task automatic test_fail_restart();
        logic [7:0] obs;
        int k;
        rst = 1'b1;
        step();
        obs = status();
        n_vec++;
        if (obs !== 8'b1100_0000) begin
            n_err++;
            $display("FAIL fail_rst_clear: got %b want %b", obs, 8'b1100_0000);
        end
        rst = 1'b0;
        pll_lock = 1'b1;
        k = 0;
        while (locked !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        obs = status();
        n_vec++;
        if (obs !== 8'b0010_0000) begin
            n_err++;
            $display("FAIL fail_restart: got %b want %b", obs, 8'b0010_0000);
        end
    endtask
`endif

    task automatic test_reset_mid_pulse();
        logic [7:0] obs, exp;
        int k;
        pll_lock = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        k = 0;
        while (locked !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        n_vec++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL midpulse_lock_wait: got locked=%b want 1", locked);
        end
        pll_lock = 1'b0;
        step();
        step();
        step();
        obs = status();
        n_vec++;
        if (obs !== 8'b1100_0100) begin
            n_err++;
            $display("FAIL midpulse_loss: got %b want %b", obs, 8'b1100_0100);
        end
        step();
        rst = 1'b1;
        step();
        obs = status();
        n_vec++;
        if (obs !== 8'b1100_0000) begin
            n_err++;
            $display("FAIL midpulse_reset: got %b want %b", obs, 8'b1100_0000);
        end
        rst = 1'b0;
        // Pulse restarts at full length after reset.
        for (int c = 1; c <= 5; c++) begin
            step();
            exp = {(c < 4), 1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
            obs = status();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL midpulse_restart c=%0d: got %b want %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_saturation();
        logic [CW-1:0] exp_loss;
        int k;
        for (int i = 1; i <= 4; i++) begin
            pll_lock = 1'b1;
            k = 0;
            while (locked !== 1'b1 && k < 40) begin
                step();
                k++;
            end
            n_vec++;
            if (locked !== 1'b1 || retry_cnt !== 2'd0) begin
                n_err++;
                $display("FAIL sat_relock i=%0d: got locked=%b retry=%0d want 1/0",
                         i, locked, retry_cnt);
            end
            pll_lock = 1'b0;
            step();
            step();
            step();
            exp_loss = (i > 3) ? 2'd3 : 2'(i);
            n_vec++;
            if (loss_cnt !== exp_loss || locked !== 1'b0 || sys_rst !== 1'b1) begin
                n_err++;
                $display("FAIL sat_loss i=%0d: got loss=%0d locked=%b sys_rst=%b want %0d/0/1",
                         i, loss_cnt, locked, sys_rst, exp_loss);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_loss_run();
        test_chatter();
        test_timeout();
`ifdef PLL_LOCK_MON_FAIL_EN
        test_fail_restart();
`endif
        test_reset_mid_pulse();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
